opb_register_simulink2ppc: RTL

OPB_REGISTER_SIMULINK2PPC -- requirements
Module: opb_register_simulink2ppc

---
 rtl/opb_register_simulink2ppc.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/opb_register_simulink2ppc.sv
// OPB slave exposing a fabric-captured word, a new-data flag and an overflow count to the PPC.
// Optional capture timestamp at offset 2 is enabled by defining SIMULINK2PPC_TIMESTAMP_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a decoded hit (only once select was seen low)
// ACK   | one-cycle acknowledge; read data on Sl_DBus, side effects
// WAIT  | transfer done, waiting for the master to drop OPB_select
module opb_register_simulink2ppc #(
   parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
   parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter              C_FAMILY     = "virtex6"
) (
   input  logic        OPB_Clk,
   input  logic        OPB_Rst,
   input  logic [0:31] OPB_ABus,
   input  logic [0:3]  OPB_BE,
   input  logic [0:31] OPB_DBus,
   input  logic        OPB_RNW,
   input  logic        OPB_select,
   input  logic        OPB_seqAddr,
   output logic [0:31] Sl_DBus,
   output logic        Sl_xferAck,
   output logic        Sl_errAck,
   output logic        Sl_retry,
   output logic        Sl_toutSup,
   input  logic [31:0] user_data_in,
   input  logic        user_valid
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACK  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   logic [1:0]  state;
   logic        armed;
   logic        clr_new_q;
   logic        clr_ovf_q;
   logic [31:0] data_q;
   logic        new_flag;
   logic [15:0] ovf_cnt;
   logic [31:0] rd_word;
   logic [5:0]  offset;
   logic [32:0] lo_diff;
   logic [32:0] hi_diff;
   logic        hit;
   logic        rd_clear;
   logic        ovf_clear;
   logic        ovf_inc;
   logic        unused_bits;

   assign unused_bits = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:30],
                          C_OPB_AWIDTH, C_OPB_DWIDTH, C_FAMILY};

   // 33-bit differences keep the window compare free of constant-compare warnings at base 0
   assign lo_diff = {1'b0, OPB_ABus} - {1'b0, C_BASEADDR};
   assign hi_diff = {1'b0, C_HIGHADDR} - {1'b0, OPB_ABus};
   assign hit     = OPB_select && !lo_diff[32] && !hi_diff[32];
   assign offset  = OPB_ABus[24:29];

   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;

   assign rd_clear  = (state == ST_ACK) && clr_new_q;
   assign ovf_clear = (state == ST_ACK) && clr_ovf_q;
   assign ovf_inc   = user_valid && new_flag && !rd_clear && (ovf_cnt != 16'hFFFF);

`ifdef SIMULINK2PPC_TIMESTAMP_EN
   logic [31:0] cyc_cnt;
   logic [31:0] tstamp;

   always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
      if (!OPB_Rst) begin
         cyc_cnt <= '0;
         tstamp  <= '0;
      end else begin
         cyc_cnt <= cyc_cnt + 32'd1;
         if (user_valid) tstamp <= cyc_cnt;
      end
   end
`endif

   always_comb begin
      rd_word = '0;
      case (offset)
         6'd0:    rd_word = data_q;
         6'd1:    rd_word = {ovf_cnt, 15'd0, new_flag};
`ifdef SIMULINK2PPC_TIMESTAMP_EN
         6'd2:    rd_word = tstamp;
`endif
         default: rd_word = '0;
      endcase
   end

   // read data is snapshotted at the hit so an ACK-cycle capture shows up on the next read
   always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
      if (!OPB_Rst) begin
         state      <= ST_IDLE;
         armed      <= 1'b0;
         clr_new_q  <= 1'b0;
         clr_ovf_q  <= 1'b0;
         Sl_xferAck <= 1'b0;
         Sl_DBus    <= '0;
      end else begin
         Sl_xferAck <= 1'b0;
         Sl_DBus    <= '0;
         if (!OPB_select) armed <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (hit && armed) begin
                  state      <= ST_ACK;
                  Sl_xferAck <= 1'b1;
                  if (OPB_RNW) Sl_DBus <= rd_word;
                  clr_new_q  <= OPB_RNW && (offset == 6'd0);
                  clr_ovf_q  <= !OPB_RNW && (offset == 6'd1) && OPB_BE[3] && OPB_DBus[31];
               end
            end
            ST_ACK:  state <= ST_WAIT;
            ST_WAIT: if (!OPB_select) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
      if (!OPB_Rst) begin
         data_q   <= '0;
         new_flag <= 1'b0;
         ovf_cnt  <= '0;
      end else begin
         if (user_valid) begin
            data_q   <= user_data_in;
            new_flag <= 1'b1;
         end else if (rd_clear) begin
            new_flag <= 1'b0;
         end
         if (ovf_clear)    ovf_cnt <= '0;
         else if (ovf_inc) ovf_cnt <= ovf_cnt + 16'd1;
      end
   end

endmodule
